// File: rtl/keycode_pkg.sv
// Shared types and constants for the USB keycode event controller.
// KEYCODE_RELEASE_EVENTS_EN adds the press/release flag to each queued event.
package keycode_pkg;

    localparam int         NUM_SLOTS    = 8;
    localparam logic [7:0] KEY_NONE     = 8'h00;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;

    typedef logic [NUM_SLOTS-1:0][7:0] kc_slots_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_P,
        SCAN_R,
        COMMIT
    } kc_state_t;

`ifdef KEYCODE_RELEASE_EVENTS_EN
    typedef struct packed {
        logic [7:0] code;
        logic       press;
    } kc_event_t;
`else
    typedef struct packed {
        logic [7:0] code;
    } kc_event_t;
`endif

    // USB reports ErrorRollOver in every slot when too many keys are down.
    function automatic logic has_rollover(input kc_slots_t s);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (s[i] == KEY_ROLLOVER) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/kc_event_fifo.sv
// Synchronous show-ahead FIFO of key events; head is visible whenever valid_o is high.
// Entry layout follows kc_event_t (KEYCODE_RELEASE_EVENTS_EN widens it by the press bit).
module kc_event_fifo
    import keycode_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      push_i,
    input  kc_event_t data_i,
    output logic      full_o,
    input  logic      pop_i,
    output logic      valid_o,
    output kc_event_t data_o
);

    localparam int AW = $clog2(DEPTH);

    kc_event_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/keycode_event_ctrl.sv
// Debounces the two keycode GPIO words and emits one queued event per changed key.
// Release events (SCAN_R) exist only when KEYCODE_RELEASE_EVENTS_EN is defined.
module keycode_event_ctrl
    import keycode_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] keycode0,
    input  logic [31:0] keycode1,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_code,
    output logic        evt_press,
    output logic [63:0] keys_held,
    output logic        busy
);

    localparam int            CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam int            IW      = $clog2(NUM_SLOTS);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_SLOTS - 1);

    kc_slots_t       sample;
    kc_slots_t       in_q;
    logic [CW-1:0]   cnt_q;
    kc_slots_t       snap_q, snap_d;
    kc_slots_t       held_q, held_d;
    kc_state_t       state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;

    kc_slots_t       src;
    kc_slots_t       other;
    logic [7:0]      cur_code;
    logic [NUM_SLOTS-1:0] other_hit;
    logic [NUM_SLOTS-1:0] prior_hit;
    logic            in_scan;
    logic            need_push;
    logic            fifo_full;
    logic            pop;
    logic            stall;
    kc_event_t       push_evt;
    kc_event_t       head_evt;

    assign sample = {keycode1, keycode0};

    always_ff @(posedge Clk) begin
        if (reset) begin
            in_q  <= '0;
            cnt_q <= '0;
        end else begin
            in_q <= sample;
            if (sample != in_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Press scan walks the new snapshot against the held set; release scan the reverse.
    assign in_scan  = (state_q == SCAN_P) || (state_q == SCAN_R);
    assign src      = (state_q == SCAN_R) ? held_q : snap_q;
    assign other    = (state_q == SCAN_R) ? snap_q : held_q;
    assign cur_code = src[idx_q];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
            assign other_hit[gi] = (other[gi] == cur_code);
            assign prior_hit[gi] = (IW'(gi) < idx_q) && (src[gi] == cur_code);
        end
    endgenerate

    assign need_push = in_scan && (cur_code != KEY_NONE) && !(|other_hit) && !(|prior_hit);
    assign pop       = evt_valid && evt_ready;
    assign stall     = need_push && fifo_full && !pop;

    always_comb begin
        push_evt      = '0;
        push_evt.code = cur_code;
`ifdef KEYCODE_RELEASE_EVENTS_EN
        push_evt.press = (state_q == SCAN_P);
`endif
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        held_d  = held_q;
        case (state_q)
            IDLE: begin
                if ((cnt_q == CNT_MAX) && (in_q != held_q) && !has_rollover(in_q)) begin
                    snap_d  = in_q;
                    idx_d   = '0;
                    state_d = SCAN_P;
                end
            end
            SCAN_P: begin
                if (!stall) begin
                    if (idx_q == IDX_MAX) begin
                        idx_d = '0;
`ifdef KEYCODE_RELEASE_EVENTS_EN
                        state_d = SCAN_R;
`else
                        state_d = COMMIT;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef KEYCODE_RELEASE_EVENTS_EN
            SCAN_R: begin
                if (!stall) begin
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`endif
            COMMIT: begin
                held_d  = snap_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    kc_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (Clk),
        .srst   (reset),
        .push_i (need_push),
        .data_i (push_evt),
        .full_o (fifo_full),
        .pop_i  (evt_ready),
        .valid_o(evt_valid),
        .data_o (head_evt)
    );

    assign evt_code = head_evt.code;
`ifdef KEYCODE_RELEASE_EVENTS_EN
    assign evt_press = head_evt.press;
`else
    assign evt_press = 1'b1;
`endif

    assign keys_held = held_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// Scoreboard bench for keycode_event_ctrl with STABLE_CYCLES = 4 and a 2-entry FIFO.
// Release expectations are added only when KEYCODE_RELEASE_EVENTS_EN is defined.
module tb_keycode_event_ctrl;

    localparam int STABLE = 4;
`ifdef KEYCODE_RELEASE_EVENTS_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] keycode0 = '0;
    logic [31:0] keycode1 = '0;
    logic        evt_ready = 1'b0;
    logic        evt_valid;
    logic [7:0]  evt_code;
    logic        evt_press;
    logic [63:0] keys_held;
    logic        busy;

    int          vectors = 0;
    int          errors = 0;
    logic [8:0]  sb[$];

    keycode_event_ctrl #(
        .STABLE_CYCLES(STABLE),
        .FIFO_DEPTH   (2)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .keycode0 (keycode0),
        .keycode1 (keycode1),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_press(evt_press),
        .keys_held(keys_held),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] code, input logic press);
        sb.push_back({code, press});
    endtask

    task automatic set_keys(input logic [31:0] k1, input logic [31:0] k0);
        @(posedge Clk);
        #1;
        keycode1 = k1;
        keycode0 = k0;
    endtask

    task automatic settle();
        bit done;
        done = 1'b0;
        repeat (STABLE + 4) @(posedge Clk);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge Clk);
            if (!busy && !evt_valid) done = 1'b1;
        end
        check("settle", 64'(done), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    // Every accepted event is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (!reset && evt_valid && evt_ready) begin
            logic [8:0] exp;
            $display("event code=%02h press=%0d", evt_code, evt_press);
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("evt_code", 64'(evt_code), 64'(exp[8:1]));
                check("evt_press", 64'(evt_press), 64'(exp[0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  acc;

        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;
        @(negedge Clk);
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_held", keys_held, 64'd0);
        check("rst_code", 64'(evt_code), 64'd0);
        check("rst_press", 64'(evt_press), REL_EN ? 64'd0 : 64'd1);

        // Single press, latency from input change to evt_valid
        evt_ready = 1'b1;
        push_exp(8'h04, 1'b1);
        set_keys(32'h0, 32'h0000_0004);
        for (n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (evt_valid) break;
        end
        check("latency", 64'(n), 64'd6);
        settle();
        check("held_04", keys_held, 64'h04);

        // Release to empty, then a bouncing input
        if (REL_EN) push_exp(8'h04, 1'b0);
        set_keys(32'h0, 32'h0);
        settle();
        check("held_empty", keys_held, 64'h0);
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_keys(32'h0, (i % 2 == 0) ? 32'h4 : 32'h0);
            @(negedge Clk);
            acc |= busy | evt_valid;
            @(negedge Clk);
            acc |= busy | evt_valid;
        end
        check("bounce_quiet", 64'(acc), 64'd0);
        push_exp(8'h04, 1'b1);
        set_keys(32'h0, 32'h0000_0004);
        settle();
        check("held_bounce", keys_held, 64'h04);

        // Two-key set changes: press before release
        push_exp(8'h05, 1'b1);
        set_keys(32'h0, 32'h0000_0504);
        settle();
        check("held_0504", keys_held, 64'h0504);
        push_exp(8'h16, 1'b1);
        if (REL_EN) push_exp(8'h04, 1'b0);
        set_keys(32'h0, 32'h0000_1605);
        settle();
        check("held_1605", keys_held, 64'h1605);

        // ErrorRollOver snapshot is ignored
        set_keys(32'h0, 32'h0101_0101);
        acc = 1'b0;
        repeat (16) begin
            @(negedge Clk);
            acc |= busy | evt_valid;
        end
        check("roll_quiet", 64'(acc), 64'd0);
        check("roll_held", keys_held, 64'h1605);

        // Six keys into a 2-deep FIFO with the consumer stalled
        if (REL_EN) begin
            push_exp(8'h05, 1'b0);
            push_exp(8'h16, 1'b0);
        end
        set_keys(32'h0, 32'h0);
        settle();
        check("held_clear", keys_held, 64'h0);
        @(posedge Clk);
        #1;
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) push_exp(8'(8'h0A + k), 1'b1);
        set_keys(32'h0000_0F0E, 32'h0D0C_0B0A);
        repeat (20) @(negedge Clk);
        check("full_busy", 64'(busy), 64'd1);
        check("full_valid", 64'(evt_valid), 64'd1);
        check("full_head", 64'(evt_code), 64'h0A);
        @(posedge Clk);
        #1;
        evt_ready = 1'b1;
        settle();
        check("held_six", keys_held, 64'h0000_0F0E_0D0C_0B0A);

        // Reset in the middle of a press scan with one event queued
        if (REL_EN) for (int k = 0; k < 6; k++) push_exp(8'(8'h0A + k), 1'b0);
        set_keys(32'h0, 32'h0);
        settle();
        @(posedge Clk);
        #1;
        evt_ready = 1'b0;
        push_exp(8'h31, 1'b1);
        set_keys(32'h0, 32'h0000_0031);
        for (n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (evt_valid) break;
        end
        check("pre_rst_valid", 64'(evt_valid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge Clk);
        check("mid_rst_valid", 64'(evt_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_held", keys_held, 64'h0);
        push_exp(8'h31, 1'b1);
        evt_ready = 1'b1;
        settle();
        check("held_rereport", keys_held, 64'h31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
